// File: rtl/shift_deser_rx_if.sv
// Handshake and serial-bus bundle between a serial bit source, the
// shift_deser_rx receiver and the consumer of its parallel words.
interface shift_deser_rx_if #(
  parameter int WIDTH = 4
);
  logic             ser_in;
  logic             ser_valid;
  logic             frame_start;
  logic             dir;
  logic             out_ready;
  logic             clr_err;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             busy;
  logic             overrun;
  logic             frame_err;

  modport master (
    output ser_in, ser_valid, frame_start, dir, out_ready, clr_err,
    input  p_out, p_valid, busy, overrun, frame_err
  );

  modport slave (
    input  ser_in, ser_valid, frame_start, dir, out_ready, clr_err,
    output p_out, p_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/shift_deser_rx.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first and
// hands them to a double-buffered valid/ready output with sticky error flags.
module shift_deser_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_deser_rx_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pvalid_q, pvalid_d;
  logic             overrun_q, overrun_d;
  logic             ferr_q, ferr_d;

  logic             startBit;
  logic             shiftBit;
  logic             lastBit;
  logic             wordDone;
  logic             overrunSet;
  logic             ferrSet;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] firstWord;

  always_comb begin
    startBit  = bus.ser_valid & bus.frame_start;
    shiftBit  = bus.ser_valid & ~bus.frame_start & (state_q == SHIFT);
    lastBit   = (cnt_q == CNT_W'(WIDTH - 1));
    shifted   = dir_q ? {bus.ser_in, sreg_q[WIDTH-1:1]}
                      : {sreg_q[WIDTH-2:0], bus.ser_in};
    // The first bit sits at the fill end so WIDTH-1 later shifts carry it home.
    firstWord = bus.dir ? {bus.ser_in, {(WIDTH-1){1'b0}}}
                        : {{(WIDTH-1){1'b0}}, bus.ser_in};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    dir_d    = dir_q;
    wordDone = 1'b0;
    ferrSet  = 1'b0;
    if (startBit) begin
      ferrSet = (state_q == SHIFT);
      sreg_d  = firstWord;
      dir_d   = bus.dir;
      cnt_d   = CNT_W'(1);
      state_d = SHIFT;
    end else if (shiftBit) begin
      sreg_d = shifted;
      if (lastBit) begin
        wordDone = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // A finished word may replace the held one only if that one leaves this cycle.
  always_comb begin
    pout_d     = pout_q;
    pvalid_d   = pvalid_q;
    overrunSet = 1'b0;
    if (wordDone) begin
      if (!pvalid_q || bus.out_ready) begin
        pout_d   = shifted;
        pvalid_d = 1'b1;
      end else begin
        overrunSet = 1'b1;
      end
    end else if (pvalid_q && bus.out_ready) begin
      pvalid_d = 1'b0;
    end
    overrun_d = overrunSet | (overrun_q & ~bus.clr_err);
    ferr_d    = ferrSet    | (ferr_q    & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      dir_q     <= 1'b0;
      pout_q    <= '0;
      pvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      dir_q     <= dir_d;
      pout_q    <= pout_d;
      pvalid_q  <= pvalid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.p_out     = pout_q;
  assign bus.p_valid   = pvalid_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_shift_deser_rx.sv
// Self-checking bench for shift_deser_rx: fixed vector table, hand-written
// corner sequences, then random traffic against a word-level reference model.
module tb_shift_deser_rx;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  shift_deser_rx_if #(.WIDTH(WIDTH)) bus ();

  shift_deser_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Inputs {ser_valid, ser_in, frame_start, dir, out_ready, clr_err};
  // expectations {p_valid, p_out[3:0], busy, overrun, frame_err}.
  typedef struct {
    logic [5:0] ins;
    logic [7:0] exps;
  } vec_t;

  vec_t vecs[16];

  // Reference model: collected bits of the current frame and the output buffer.
  bit             mInFrame;
  bit             mDir;
  bit             bitsQ[$];
  bit             mPv;
  logic [WIDTH-1:0] mPout;
  bit             mOv;
  bit             mFe;

  function automatic vec_t mkVec(input logic [5:0] ins, input logic [7:0] exps);
    vec_t v;
    v.ins  = ins;
    v.exps = exps;
    return v;
  endfunction

  task automatic modelReset();
    mInFrame = 1'b0;
    mDir     = 1'b0;
    bitsQ.delete();
    mPv      = 1'b0;
    mPout    = '0;
    mOv      = 1'b0;
    mFe      = 1'b0;
  endtask

  task automatic modelStep();
    bit               done;
    bit               ovSet;
    bit               feSet;
    logic [WIDTH-1:0] word;
    done  = 1'b0;
    ovSet = 1'b0;
    feSet = 1'b0;
    word  = '0;
    if (bus.ser_valid) begin
      if (bus.frame_start) begin
        if (mInFrame) feSet = 1'b1;
        bitsQ.delete();
        bitsQ.push_back(bus.ser_in);
        mDir     = bus.dir;
        mInFrame = 1'b1;
      end else if (mInFrame) begin
        bitsQ.push_back(bus.ser_in);
        if (bitsQ.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++)
            word[mDir ? i : WIDTH - 1 - i] = bitsQ[i];
          done     = 1'b1;
          mInFrame = 1'b0;
          bitsQ.delete();
        end
      end
    end
    if (done) begin
      if (!mPv || bus.out_ready) begin
        mPout = word;
        mPv   = 1'b1;
      end else begin
        ovSet = 1'b1;
      end
    end else if (mPv && bus.out_ready) begin
      mPv = 1'b0;
    end
    mOv = ovSet | (mOv & ~bus.clr_err);
    mFe = feSet | (mFe & ~bus.clr_err);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic pv, input logic [WIDTH-1:0] po,
                          input logic bz, input logic ov, input logic fe);
    checkOutput({tag, ".p_valid"},   32'(bus.p_valid),   32'(pv));
    checkOutput({tag, ".p_out"},     32'(bus.p_out),     32'(po));
    checkOutput({tag, ".busy"},      32'(bus.busy),      32'(bz));
    checkOutput({tag, ".overrun"},   32'(bus.overrun),   32'(ov));
    checkOutput({tag, ".frame_err"}, 32'(bus.frame_err), 32'(fe));
  endtask

  // Drives one cycle of inputs on the falling edge, then samples 1 ns past the rising edge.
  task automatic applyStimulus(input logic sv, input logic sin, input logic fs,
                               input logic d, input logic rdy, input logic clr);
    @(negedge clk);
    bus.ser_valid   = sv;
    bus.ser_in      = sin;
    bus.frame_start = fs;
    bus.dir         = d;
    bus.out_ready   = rdy;
    bus.clr_err     = clr;
    @(posedge clk);
    if (rst_n) modelStep();
    #1;
  endtask

  task automatic idleInputs();
    bus.ser_valid   = 1'b0;
    bus.ser_in      = 1'b0;
    bus.frame_start = 1'b0;
    bus.dir         = 1'b0;
    bus.out_ready   = 1'b0;
    bus.clr_err     = 1'b0;
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] w, input logic d, input logic rdyLast);
    for (int i = 0; i < WIDTH; i++)
      applyStimulus(1'b1, d ? w[i] : w[WIDTH-1-i], i == 0, d,
                    (i == WIDTH - 1) ? rdyLast : 1'b0, 1'b0);
  endtask

  task automatic doReset(input bit withChecks);
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ser_valid   = 1'($urandom_range(1));
      bus.ser_in      = 1'($urandom_range(1));
      bus.frame_start = 1'($urandom_range(1));
      bus.dir         = 1'($urandom_range(1));
      bus.out_ready   = 1'($urandom_range(1));
      bus.clr_err     = 1'($urandom_range(1));
      @(posedge clk);
      #1;
      if (withChecks) checkAll("inReset", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    idleInputs();
    #2 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("postReset", 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    idleInputs();
    modelReset();

    vecs[0]  = mkVec(6'b111010, 8'b0_0000_100);
    vecs[1]  = mkVec(6'b100010, 8'b0_0000_100);
    vecs[2]  = mkVec(6'b110010, 8'b0_0000_100);
    vecs[3]  = mkVec(6'b110010, 8'b1_1011_000);
    vecs[4]  = mkVec(6'b000010, 8'b0_1011_000);
    vecs[5]  = mkVec(6'b111110, 8'b0_1011_100);
    vecs[6]  = mkVec(6'b000010, 8'b0_1011_100);
    vecs[7]  = mkVec(6'b000010, 8'b0_1011_100);
    vecs[8]  = mkVec(6'b100010, 8'b0_1011_100);
    vecs[9]  = mkVec(6'b000010, 8'b0_1011_100);
    vecs[10] = mkVec(6'b000010, 8'b0_1011_100);
    vecs[11] = mkVec(6'b110010, 8'b0_1011_100);
    vecs[12] = mkVec(6'b000010, 8'b0_1011_100);
    vecs[13] = mkVec(6'b000010, 8'b0_1011_100);
    vecs[14] = mkVec(6'b110010, 8'b1_1101_000);
    vecs[15] = mkVec(6'b000010, 8'b0_1101_000);

    doReset(1'b1);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].ins[5], vecs[i].ins[4], vecs[i].ins[3],
                    vecs[i].ins[2], vecs[i].ins[1], vecs[i].ins[0]);
      checkAll($sformatf("vec%0d", i), vecs[i].exps[7], vecs[i].exps[6:3],
               vecs[i].exps[2], vecs[i].exps[1], vecs[i].exps[0]);
    end

    // Back-pressure: the second word is dropped and flagged.
    sendWord(4'hA, 1'b0, 1'b0);
    checkAll("ovrFirst", 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    sendWord(4'h5, 1'b0, 1'b0);
    checkAll("ovrSecond", 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("ovrDrain", 1'b0, 4'hA, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkAll("ovrClear", 1'b0, 4'hA, 1'b0, 1'b0, 1'b0);

    // Completion coinciding with acceptance of the held word.
    sendWord(4'h3, 1'b0, 1'b0);
    checkAll("simFirst", 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    sendWord(4'hC, 1'b0, 1'b1);
    checkAll("simSecond", 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("simDrain", 1'b0, 4'hC, 1'b0, 1'b0, 1'b0);

    // Restart after two bits; the clear in the same cycle loses to the new error.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("rstrtPart", 1'b0, 4'hC, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkAll("rstrtErr", 1'b0, 4'hC, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("rstrtWord", 1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkAll("rstrtClear", 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame with a word pending.
    sendWord(4'h9, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("midPre", 1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkAll("midAsync", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idleInputs();
    #2 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("midAfter", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the reference model.
    doReset(1'b0);
    for (int n = 0; n < 2000; n++) begin
      applyStimulus($urandom_range(3) != 0, 1'($urandom_range(1)),
                    $urandom_range(7) == 0, 1'($urandom_range(1)),
                    1'($urandom_range(1)), $urandom_range(15) == 0);
      checkAll($sformatf("rand%0d", n), mPv, mPout, mInFrame, mOv, mFe);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
